// File: rtl/ddfs_pkg.sv
// Shared constants and types for the DDFS phase accumulator and sine LUT.
package ddfs_pkg;

  localparam int ADDR_WIDTH = 7;
  localparam int LUT_DEPTH  = 86;
  localparam int FRAC_WIDTH = 16;
  localparam int FTW_WIDTH  = ADDR_WIDTH + FRAC_WIDTH;

  // One bit wider than the phase so a full 2**ADDR_WIDTH table still fits.
  localparam logic [FTW_WIDTH:0] PHASE_MOD = (FTW_WIDTH+1)'(LUT_DEPTH) << FRAC_WIDTH;

  typedef logic [FTW_WIDTH-1:0] phase_t;

endpackage

// File: rtl/ddfs_mod_adder.sv
// Combinational modulo-MOD adder: {sum, wrapped} = (a + b) mod MOD, for a, b < MOD.
module ddfs_mod_adder #(
  parameter int         W   = ddfs_pkg::FTW_WIDTH,
  parameter logic [W:0] MOD = ddfs_pkg::PHASE_MOD
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         wrapped
);

  logic [W:0] raw;

  // Both operands are below MOD, so one conditional subtraction is enough.
  always_comb begin
    raw     = {1'b0, a} + {1'b0, b};
    wrapped = (raw >= MOD);
    sum     = wrapped ? W'(raw - MOD) : W'(raw);
  end

endmodule

// File: rtl/ddfs_phase_acc.sv
// Modulo phase accumulator / LUT address generator for the DDFS.
// Define DDFS_PHASE_ROUND_EN to round the address to nearest instead of truncating.
module ddfs_phase_acc #(
  parameter int ADDR_WIDTH = ddfs_pkg::ADDR_WIDTH,
  parameter int LUT_DEPTH  = ddfs_pkg::LUT_DEPTH,
  parameter int FRAC_WIDTH = ddfs_pkg::FRAC_WIDTH,
  parameter int FTW_WIDTH  = ADDR_WIDTH + FRAC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [FTW_WIDTH-1:0]  ftw_in,
  input  logic                  ftw_load,
  input  logic                  phase_clr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  addr_valid,
  output logic                  wrap
);

  localparam logic [FTW_WIDTH:0]   PHASE_MOD = (FTW_WIDTH+1)'(LUT_DEPTH) << FRAC_WIDTH;
  localparam logic [FTW_WIDTH-1:0] FTW_MAX   = FTW_WIDTH'(PHASE_MOD - 1'b1);

  logic [FTW_WIDTH-1:0]  phase_q, phase_d;
  logic [FTW_WIDTH-1:0]  ftw_q, ftw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  addr_valid_q, addr_valid_d;
  logic                  wrap_q, wrap_d;

  logic [FTW_WIDTH-1:0]  sum;
  logic                  wrapped;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  unused_frac_bits;

  ddfs_mod_adder #(
    .W   (FTW_WIDTH),
    .MOD (PHASE_MOD)
  ) u_mod_adder (
    .a       (phase_q),
    .b       (ftw_q),
    .sum     (sum),
    .wrapped (wrapped)
  );

  assign unused_frac_bits = ^sum[FRAC_WIDTH-1:0];

`ifdef DDFS_PHASE_ROUND_EN
  logic [ADDR_WIDTH:0] addr_rnd;

  // Rounding past the last entry folds to 0 without signalling a wrap.
  always_comb begin
    addr_rnd  = {1'b0, sum[FTW_WIDTH-1:FRAC_WIDTH]} + (ADDR_WIDTH+1)'(sum[FRAC_WIDTH-1]);
    addr_next = (addr_rnd == (ADDR_WIDTH+1)'(LUT_DEPTH)) ? '0 : addr_rnd[ADDR_WIDTH-1:0];
  end
`else
  assign addr_next = sum[FTW_WIDTH-1:FRAC_WIDTH];
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ftw_d        = ftw_q;
    phase_d      = phase_q;
    addr_d       = addr_q;
    wrap_d       = 1'b0;
    addr_valid_d = en;

    if (ftw_load) begin
      ftw_d = ({1'b0, ftw_in} >= PHASE_MOD) ? FTW_MAX : ftw_in;
    end

    if (phase_clr) begin
      phase_d = '0;
      addr_d  = '0;
    end else if (en) begin
      phase_d = sum;
      addr_d  = addr_next;
      wrap_d  = wrapped;
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= '0;
      ftw_q        <= '0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      ftw_q        <= ftw_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      wrap_q       <= wrap_d;
    end
  end

  assign addr       = addr_q;
  assign addr_valid = addr_valid_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_ddfs_phase_acc.sv
// Directed self-checking bench for ddfs_phase_acc at default parameters.
module tb_ddfs_phase_acc;

  localparam int PHASE_MOD = 86 * 65536;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [22:0] ftw_in;
  logic        ftw_load;
  logic        phase_clr;
  logic [6:0]  addr;
  logic        addr_valid;
  logic        wrap;

  int checks = 0;
  int errors = 0;
  int exp_phase;
  int exp_wrap;

  always #5 clk = ~clk;

  ddfs_phase_acc dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ftw_in     (ftw_in),
    .ftw_load   (ftw_load),
    .phase_clr  (phase_clr),
    .addr       (addr),
    .addr_valid (addr_valid),
    .wrap       (wrap)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_addr(input int p);
`ifdef DDFS_PHASE_ROUND_EN
    int a;
    a = (p + 32768) >> 16;
    if (a == 86) a = 0;
    return a;
`else
    return p >> 16;
`endif
  endfunction

  task automatic model_step(input int ftw);
    exp_phase += ftw;
    if (exp_phase >= PHASE_MOD) begin
      exp_phase -= PHASE_MOD;
      exp_wrap = 1;
    end else begin
      exp_wrap = 0;
    end
  endtask

  initial begin
    // Reset held with en and ftw_load active
    rst = 1'b1; en = 1'b1; ftw_load = 1'b1; ftw_in = 23'h010000; phase_clr = 1'b0;
    step(); step();
    check("rst_addr", addr, 0);
    check("rst_valid", addr_valid, 0);
    check("rst_wrap", wrap, 0);

    rst = 1'b0; ftw_load = 1'b0;
    step();
    check("zero_ftw_addr", addr, 0);
    check("zero_ftw_valid", addr_valid, 1);
    step();
    check("zero_ftw_hold", addr, 0);

    // Step 1.0: load takes effect one edge later
    ftw_load = 1'b1; ftw_in = 23'h010000;
    step();
    ftw_load = 1'b0;
    check("load_latency", addr, 0);
    for (int i = 1; i <= 86; i++) begin
      step();
      check("step1_addr", addr, i % 86);
      check("step1_wrap", wrap, (i == 86) ? 1 : 0);
    end

    // phase_clr at addr 40
    for (int i = 0; i < 40; i++) step();
    check("pre_clr_addr", addr, 40);
    phase_clr = 1'b1;
    step();
    phase_clr = 1'b0;
    check("clr_addr", addr, 0);
    check("clr_wrap", wrap, 0);
    check("clr_valid", addr_valid, 1);
    step(); check("post_clr_1", addr, 1);
    step(); check("post_clr_2", addr, 2);

    // Drop en
    en = 1'b0;
    step();
    check("en_low_addr", addr, 2);
    check("en_low_valid", addr_valid, 0);
    check("en_low_wrap", wrap, 0);
    step(); check("en_low_hold", addr, 2);
    en = 1'b1;
    step();
    check("en_high_addr", addr, 3);
    check("en_high_valid", addr_valid, 1);

    // Reload 2.0 mid-run: old word used on the load edge
    ftw_load = 1'b1; ftw_in = 23'h020000;
    step();
    ftw_load = 1'b0;
    check("reload_old", addr, 4);
    step(); check("reload_new", addr, 6);

    // Mid-run reset discards the tuning word
    rst = 1'b1;
    step();
    check("midrst_addr", addr, 0);
    check("midrst_valid", addr_valid, 0);
    rst = 1'b0;
    step();
    check("midrst_ftw_gone", addr, 0);
    check("midrst_valid_back", addr_valid, 1);
    step(); check("midrst_ftw_gone2", addr, 0);

    // Step 0.5, loaded during phase_clr
    phase_clr = 1'b1; ftw_load = 1'b1; ftw_in = 23'h008000;
    step();
    phase_clr = 1'b0; ftw_load = 1'b0;
    check("half_clr_addr", addr, 0);
    exp_phase = 0;
    for (int i = 1; i <= 172; i++) begin
      step();
      model_step(32'h8000);
      check("half_addr", addr, exp_addr(exp_phase));
      check("half_wrap", wrap, exp_wrap);
    end

    // Step 3.0
    phase_clr = 1'b1; ftw_load = 1'b1; ftw_in = 23'h030000;
    step();
    phase_clr = 1'b0; ftw_load = 1'b0;
    exp_phase = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      model_step(32'h30000);
      check("three_addr", addr, exp_addr(exp_phase));
      check("three_wrap", wrap, exp_wrap);
      if (i == 29) begin
        check("three_wrap_addr", addr, 1);
        check("three_wrap_flag", wrap, 1);
      end
    end

    // Out-of-range word saturates to PHASE_MOD-1
    phase_clr = 1'b1; ftw_load = 1'b1; ftw_in = 23'h7FFFFF;
    step();
    phase_clr = 1'b0; ftw_load = 1'b0;
    exp_phase = 0;
    for (int i = 1; i <= 65537; i++) begin
      step();
      model_step(PHASE_MOD - 1);
      if (i == 1 || i == 2 || i == 65536 || i == 65537) begin
        check("sat_addr", addr, exp_addr(exp_phase));
        check("sat_wrap", wrap, exp_wrap);
      end
`ifndef DDFS_PHASE_ROUND_EN
      if (i == 65536) check("sat_last85", addr, 85);
      if (i == 65537) check("sat_first84", addr, 84);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
